offchip_mem_responder: RTL
==========================

Name: offchip_mem_responder

Overview:
- Synthesizable model of the byte-wide off-chip memory that sits directly downstream of the HLS accelerator's master memory ports.
- Consumes the Mout_* request buses.
- Produces M_Rdata_ram and M_DataRdy with configurable read and write latency.
- Provides a preload port, so the bench and FPGA-in-the-loop harnesses can share one memory agent instead of per-test inline models.

Parameters:
- N_CH, 2: number of independent memory channels.
- ADDR_W, 7: address bits per channel.
- BASE_ADDR, 0: first address served.
- MEMSIZE, 32: bytes served; the window is [BASE_ADDR, BASE_ADDR+MEMSIZE).
- READ_DELAY, 2: cycles from read request to DataRdy; must be ≥1.
- WRITE_DELAY, 1: cycles from write request to DataRdy; must be ≥1.

Ports:
- clock, in, 1: sole clock, rising edge.
- reset, in, 1: synchronous, active-high.
- Mout_oe_ram, in, N_CH: per-channel read enable.
- Mout_we_ram, in, N_CH: per-channel write enable.
- Mout_addr_ram, in, N_CH*ADDR_W: channel c address is bits [c*ADDR_W +: ADDR_W].
- Mout_Wdata_ram, in, N_CH*8: per-channel write byte.
- Mout_data_ram_size, in, N_CH*4: per-channel access size in bits (0..8).
- Sout_Rdata_ram, in, N_CH*8: slave read data, ORed into the output.
- Sout_DataRdy, in, N_CH: slave ready, ORed into the output.
- M_Rdata_ram, out, N_CH*8: read data returned to the accelerator.
- M_DataRdy, out, N_CH: per-channel access complete.
- init_we, in, 1: preload write strobe.
- init_addr, in, ADDR_W: preload address, absolute.
- init_data, in, 8: preload byte.
- err_conflict, out, N_CH: sticky flag, set when oe and we are high together on a channel.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Reset values:
  - M_DataRdy and M_Rdata_ram: zero-driven (apart from the Sout_* OR terms).
  - Latency counters, read pipeline and err_conflict: 0.
  - Memory array: not cleared; contents survive reset.
- Window check: in_range(c) = BASE_ADDR ≤ addr(c) < BASE_ADDR+MEMSIZE, computed in ADDR_W+1 bits so there is no wrap.
  - Out-of-range accesses: no memory effect, DataRdy contributes 0, read data contributes 0.
- Mask: mask(c) = (1<<size) - 1 for size 0..7; 0xFF for size ≥ 8.
- Per-channel latency counter cnt (integer, 0..READ_DELAY-1):
  - Read: oe high, we low, in range. cnt advances each cycle the request is held. At cnt == READ_DELAY-1, DataRdy is asserted combinationally in that cycle and cnt returns to 0 at the next edge.
  - Write: we high, oe low, in range. Same counter rule with WRITE_DELAY. WRITE_DELAY=1 means DataRdy is high in the same cycle as the request.
  - Otherwise cnt returns to 0 at the next edge. Dropping a request mid-count aborts it and gives no DataRdy.
- Read data path:
  - mem[addr-BASE_ADDR] (or 0 when out of range) enters a READ_DELAY-1 stage register pipeline.
  - M_Rdata_ram(c) = pipe_out(c) | Sout_Rdata_ram(c).
  - READ_DELAY=1: the path is combinational.
- Write commit:
  - Every edge with a valid write: mem[a] <= (wdata & mask) | (mem[a] & ~mask).
  - Repeated commits while we is held are idempotent.
- Priority on the same byte in the same cycle: higher channel index > lower channel index > init port.
- Read vs. write on the same byte in the same cycle: the read samples the pre-write value (read-before-write).
- Conflict (oe & we both high on channel c):
  - err_conflict[c] set, cleared only by reset.
  - The access is ignored: no write, no DataRdy, cnt returns to 0.
- Preload: init_we writes init_data to init_addr-BASE_ADDR when in range, regardless of reset. It uses a full byte mask.
- Reset mid-access: cnt and pipeline are cleared; the same-cycle write is still suppressed (reset has priority over a channel commit).

Decomposition:
- Shared package holds:
  - constants SIZE_W=4 and BYTE_W=8;
  - function size_to_mask;
  - function in_window(addr, base, size).
- One sub-module, offchip_mem_chan_ctrl, instantiated N_CH times: latency counter, DataRdy logic, read pipeline, conflict flag.
- The byte array and write-priority logic live in the top level.

Test Plan:
1. Preload mem[3]=0xA5 via init. Ch0 read at addr 3 (READ_DELAY=2) → M_DataRdy[0]=1 in the 2nd request cycle, M_Rdata_ram[7:0]=0xA5.
2. Ch1 write 0x3C to addr 5, size 4, with mem[5]=0xF0 → mem[5]=0xFC; M_DataRdy[1]=1 in the request cycle.
3. Both channels write addr 7 in the same cycle (0x11 on ch0, 0x22 on ch1) → mem[7]=0x22. A ch0 read issued in that cycle returns the prior value.
4. Ch0 read at addr 40 (out of window) → M_DataRdy[0]=0 and data 0. Inject Sout_DataRdy[0]=1 with Sout_Rdata=0x5A → outputs 1 and 0x5A.
5. Ch0 with oe=we=1 → err_conflict[0]=1 next cycle, memory unchanged. Assert reset → flag clears, and mem[3] still reads 0xA5.

Source files
------------

// File: rtl/offchip_mem_responder_pkg.sv
// Shared constants and helpers for the off-chip memory responder.
package offchip_mem_responder_pkg;

  localparam int unsigned SIZE_W = 4;
  localparam int unsigned BYTE_W = 8;

  // Byte-lane mask for an access of 'size' bits; 8 or more selects the whole byte.
  function automatic logic [BYTE_W-1:0] size_to_mask(input logic [SIZE_W-1:0] size);
    logic [BYTE_W-1:0] m;
    if (size >= SIZE_W'(BYTE_W)) begin
      m = '1;
    end else begin
      m = BYTE_W'((9'd1 << size) - 9'd1);
    end
    return m;
  endfunction

  // Window test done in 32 bits so base+size never wraps for any legal ADDR_W.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    return (addr >= base) && (addr < (base + size));
  endfunction

endpackage

// File: rtl/offchip_mem_chan_ctrl.sv
// Per-channel control: latency counter, DataRdy generation, read-data
// pipeline and sticky oe/we conflict flag.
module offchip_mem_chan_ctrl
  import offchip_mem_responder_pkg::*;
#(
  parameter int unsigned READ_DELAY  = 2,
  parameter int unsigned WRITE_DELAY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              oe,
  input  logic              we,
  input  logic              in_range,
  input  logic [BYTE_W-1:0] rd_byte,
  input  logic [BYTE_W-1:0] sout_rdata,
  input  logic              sout_rdy,
  output logic [BYTE_W-1:0] rdata,
  output logic              data_rdy,
  output logic              wr_commit,
  output logic              err_conflict
);

  localparam int unsigned MAX_DELAY = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
  localparam int unsigned CNT_W     = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam int unsigned PIPE_N    = (READ_DELAY > 1) ? READ_DELAY - 1 : 1;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [BYTE_W-1:0] pipe_q [PIPE_N];
  logic [BYTE_W-1:0] pipe_d [PIPE_N];
  logic              rd_req, wr_req, last;
  logic [BYTE_W-1:0] pipe_out;

  // Request decode, counter advance and pipeline shift.
  always_comb begin
    rd_req = oe & ~we & in_range;
    wr_req = we & ~oe & in_range;
    // '>=' rather than '==' so a request that changes kind mid-count still terminates.
    last = (rd_req && ((32'(cnt_q) + 32'd1) >= READ_DELAY)) ||
           (wr_req && ((32'(cnt_q) + 32'd1) >= WRITE_DELAY));
    cnt_d = '0;
    if ((rd_req || wr_req) && !last) begin
      cnt_d = cnt_q + 1'b1;
    end
    err_d = err_q | (oe & we);
    pipe_d[0] = rd_byte;
    for (int unsigned i = 1; i < PIPE_N; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Reset clears counter, pipeline and conflict flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
      for (int unsigned i = 0; i < PIPE_N; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      pipe_q <= pipe_d;
    end
  end

  // A single-cycle read latency bypasses the pipeline entirely.
  assign pipe_out     = (READ_DELAY == 1) ? rd_byte : pipe_q[PIPE_N-1];
  assign rdata        = pipe_out | sout_rdata;
  assign data_rdy     = (last & ~reset) | sout_rdy;
  assign wr_commit    = wr_req & ~reset;
  assign err_conflict = err_q;

endmodule

// File: rtl/offchip_mem_responder.sv
// Byte-wide off-chip memory model serving N_CH master channels with
// configurable read/write latency and a preload port.
module offchip_mem_responder
  import offchip_mem_responder_pkg::*;
#(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned MEMSIZE     = 32,
  parameter int unsigned READ_DELAY  = 2,
  parameter int unsigned WRITE_DELAY = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_CH-1:0]          Mout_oe_ram,
  input  logic [N_CH-1:0]          Mout_we_ram,
  input  logic [N_CH*ADDR_W-1:0]   Mout_addr_ram,
  input  logic [N_CH*BYTE_W-1:0]   Mout_Wdata_ram,
  input  logic [N_CH*SIZE_W-1:0]   Mout_data_ram_size,
  input  logic [N_CH*BYTE_W-1:0]   Sout_Rdata_ram,
  input  logic [N_CH-1:0]          Sout_DataRdy,
  output logic [N_CH*BYTE_W-1:0]   M_Rdata_ram,
  output logic [N_CH-1:0]          M_DataRdy,
  input  logic                     init_we,
  input  logic [ADDR_W-1:0]        init_addr,
  input  logic [BYTE_W-1:0]        init_data,
  output logic [N_CH-1:0]          err_conflict
);

  localparam int unsigned IDX_W = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;

  logic [BYTE_W-1:0] mem_q [MEMSIZE];
  logic [BYTE_W-1:0] mem_d [MEMSIZE];
  logic [N_CH-1:0]   ch_in_range;
  logic [N_CH-1:0]   ch_commit;
  logic [IDX_W-1:0]  ch_idx     [N_CH];
  logic [BYTE_W-1:0] ch_rd_byte [N_CH];
  logic [BYTE_W-1:0] ch_mask    [N_CH];
  logic              init_in_range;
  logic [IDX_W-1:0]  init_idx;

  // Per-channel address decode and memory read.
  always_comb begin
    for (int unsigned c = 0; c < N_CH; c++) begin
      ch_in_range[c] = in_window(32'(Mout_addr_ram[c*ADDR_W +: ADDR_W]), BASE_ADDR, MEMSIZE);
      ch_idx[c]      = IDX_W'(32'(Mout_addr_ram[c*ADDR_W +: ADDR_W]) - BASE_ADDR);
      ch_rd_byte[c]  = ch_in_range[c] ? mem_q[ch_idx[c]] : '0;
      ch_mask[c]     = size_to_mask(Mout_data_ram_size[c*SIZE_W +: SIZE_W]);
    end
    init_in_range = in_window(32'(init_addr), BASE_ADDR, MEMSIZE);
    init_idx      = IDX_W'(32'(init_addr) - BASE_ADDR);
  end

  // Next memory image: init first, then channels in ascending order so the
  // highest channel wins a same-byte collision. Merges use the pre-edge byte.
  always_comb begin
    mem_d = mem_q;
    if (init_we && init_in_range) begin
      mem_d[init_idx] = init_data;
    end
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (ch_commit[c]) begin
        mem_d[ch_idx[c]] = (Mout_Wdata_ram[c*BYTE_W +: BYTE_W] & ch_mask[c]) |
                           (mem_q[ch_idx[c]] & ~ch_mask[c]);
      end
    end
  end

  // Memory array is deliberately outside reset so contents survive it.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    offchip_mem_chan_ctrl #(
      .READ_DELAY  (READ_DELAY),
      .WRITE_DELAY (WRITE_DELAY)
    ) u_ctrl (
      .clock        (clock),
      .reset        (reset),
      .oe           (Mout_oe_ram[c]),
      .we           (Mout_we_ram[c]),
      .in_range     (ch_in_range[c]),
      .rd_byte      (ch_rd_byte[c]),
      .sout_rdata   (Sout_Rdata_ram[c*BYTE_W +: BYTE_W]),
      .sout_rdy     (Sout_DataRdy[c]),
      .rdata        (M_Rdata_ram[c*BYTE_W +: BYTE_W]),
      .data_rdy     (M_DataRdy[c]),
      .wr_commit    (ch_commit[c]),
      .err_conflict (err_conflict[c])
    );
  end

endmodule
